// File: rtl/fft_disp_pkg.sv
// fft_disp_pkg: shared constants, write FSM states and magnitude helper
// for the FFT spectrum frame buffer.
package fft_disp_pkg;
    localparam int FFT_POINT   = 256;
    localparam int V_ACT       = 720;
    localparam int SCALE_SHIFT = 6;
    localparam int PEAK_DECAY  = 2;
    localparam int AW          = $clog2(FFT_POINT);
    localparam int HW          = $clog2(V_ACT);
    localparam int FFT_DATA_W  = 32;
    localparam int HEIGHT_LSB  = 0;
    localparam int PEAK_LSB    = 16;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;

    // -32768 has no positive 16-bit twin, so it saturates to 32767
    function automatic logic [14:0] abs15(input logic [15:0] v);
        return (v == 16'h8000) ? 15'h7fff : (v[15] ? 15'(-v) : v[14:0]);
    endfunction
endpackage

// File: rtl/spec_bank_ram.sv
// spec_bank_ram: simple dual-port RAM, one write port and one registered read port;
// the address MSB selects the bank when used as a ping-pong buffer.
module spec_bank_ram #(
    parameter int AW = 9,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_spectrum_buf.sv
// fft_spectrum_buf: converts FFT bins to bar and decaying peak heights in a ping-pong
// frame buffer; the display bank swaps only on a vsync rising edge after a full frame.
module fft_spectrum_buf
    import fft_disp_pkg::*;
(
    input  logic                  pix_clk,
    input  logic                  rstn,
    input  logic                  fft_tvalid,
    output logic                  fft_tready,
    input  logic                  fft_tlast,
    input  logic [15:0]           fft_re,
    input  logic [15:0]           fft_im,
    input  logic                  vs_in,
    input  logic                  data_req,
    input  logic [9:0]            RAM_address,
    output logic [FFT_DATA_W-1:0] fft_data,
    output logic                  frame_err
);
    wr_state_t state, state_n;
    logic [AW-1:0] cnt, clr_cnt, s1_idx, s2_idx, pk_waddr;
    logic clearing, rd_bank, disp_valid, vs_r, vs_rr, zero_q;
    logic s1_v, s1_end, s1_good, s2_v, s2_end, s2_good;
    logic beat, at_last, term, good, vs_edge, pk_we;
    logic [14:0] s1_a, s1_b, mx, mn;
    logic [15:0] mag, scaled;
    logic [HW-1:0] h, s2_h, peak_old, dec, new_peak, pk_wdata;
    logic [FFT_DATA_W-1:0] bar_wdata, bank_rd;

    assign beat       = fft_tvalid & fft_tready;
    assign at_last    = cnt == AW'(FFT_POINT - 1);
    assign term       = beat & (fft_tlast | at_last);
    assign good       = fft_tlast & at_last;
    assign vs_edge    = vs_r & ~vs_rr;
    // the two cycles after a terminating beat are held off so a new frame never
    // reads a peak whose read-modify-write is still in flight
    assign fft_tready = ~clearing & (state != DONE) & ~s1_end & ~s2_end;

    always_comb begin
        state_n = state;
        if (state == DONE) state_n = vs_edge ? IDLE : DONE;
        else if (s2_end && s2_good) state_n = DONE;
        else if (term) state_n = good ? WRITE : IDLE;
        else if (beat) state_n = WRITE;
    end

    always_ff @(posedge pix_clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            clearing   <= 1'b1;
            clr_cnt    <= '0;
            rd_bank    <= 1'b0;
            disp_valid <= 1'b0;
            vs_r       <= 1'b0;
            vs_rr      <= 1'b0;
            frame_err  <= 1'b0;
            s1_v       <= 1'b0;
            s1_end     <= 1'b0;
            s2_v       <= 1'b0;
            s2_end     <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state     <= state_n;
            vs_r      <= vs_in;
            vs_rr     <= vs_r;
            frame_err <= term & ~good;
            s1_v      <= beat;
            s1_end    <= term;
            s2_v      <= s1_v;
            s2_end    <= s1_end;
            if (clearing) clr_cnt <= clr_cnt + 1'b1;
            if (clearing && clr_cnt == AW'(FFT_POINT - 1)) clearing <= 1'b0;
            if (beat) cnt <= term ? '0 : cnt + 1'b1;
            if (state == DONE && vs_edge) begin
                rd_bank    <= ~rd_bank;
                disp_valid <= 1'b1;
            end
            if (data_req) zero_q <= ~(disp_valid && RAM_address < 10'(FFT_POINT));
        end
    end

    always_ff @(posedge pix_clk) begin
        s1_idx  <= cnt;
        s1_a    <= abs15(fft_re);
        s1_b    <= abs15(fft_im);
        s1_good <= good;
        s2_idx  <= s1_idx;
        s2_h    <= h;
        s2_good <= s1_good;
    end

    assign mx     = (s1_a > s1_b) ? s1_a : s1_b;
    assign mn     = (s1_a > s1_b) ? s1_b : s1_a;
    assign mag    = {1'b0, mx} + {2'b0, mn[14:1]};
    assign scaled = mag >> SCALE_SHIFT;
    assign h      = (scaled > 16'(V_ACT - 1)) ? HW'(V_ACT - 1) : scaled[HW-1:0];

    assign dec       = (peak_old > HW'(PEAK_DECAY)) ? peak_old - HW'(PEAK_DECAY) : '0;
    assign new_peak  = (s2_h > dec) ? s2_h : dec;
    assign bar_wdata = (FFT_DATA_W'(new_peak) << PEAK_LSB) | (FFT_DATA_W'(s2_h) << HEIGHT_LSB);
    assign pk_we     = clearing | s2_v;
    assign pk_waddr  = clearing ? clr_cnt : s2_idx;
    assign pk_wdata  = clearing ? '0 : new_peak;
    assign fft_data  = zero_q ? '0 : bank_rd;

    // bar bank carries the peak too, so the display sees peaks frozen with its frame
    spec_bank_ram #(.AW(AW + 1), .W(FFT_DATA_W)) bar_ram (
        .clk(pix_clk), .we(s2_v), .waddr({~rd_bank, s2_idx}), .wdata(bar_wdata),
        .re(data_req), .raddr({rd_bank, RAM_address[AW-1:0]}), .rdata(bank_rd)
    );

    spec_bank_ram #(.AW(AW), .W(HW)) peak_ram (
        .clk(pix_clk), .we(pk_we), .waddr(pk_waddr), .wdata(pk_wdata),
        .re(1'b1), .raddr(s1_idx), .rdata(peak_old)
    );
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// tb_fft_spectrum_buf: randomized frames against a frame-level reference model;
// read responses are queued at issue and checked by a separate monitor.
module tb_fft_spectrum_buf;
    localparam int N = 256;

    logic pix_clk = 0, rstn = 0, fft_tvalid = 0, fft_tlast = 0, vs_in = 0, data_req = 0;
    logic fft_tready, frame_err;
    logic signed [15:0] fft_re = 0, fft_im = 0;
    logic [9:0] RAM_address = 0;
    logic [31:0] fft_data;

    int checks = 0, errors = 0, err_seen = 0, err_exp = 0, cyc = 0;
    int peak_m[N];
    logic [31:0] disp_m[N], pend_m[N];
    bit disp_v = 0, frame_ready = 0, chk_en = 0, chk_d = 0;
    logic [31:0] last_exp = 0;
    logic [31:0] exp_q[$];
    logic signed [15:0] fr[N], fi[N];

    fft_spectrum_buf dut (
        .pix_clk(pix_clk), .rstn(rstn), .fft_tvalid(fft_tvalid), .fft_tready(fft_tready),
        .fft_tlast(fft_tlast), .fft_re(fft_re), .fft_im(fft_im), .vs_in(vs_in),
        .data_req(data_req), .RAM_address(RAM_address), .fft_data(fft_data),
        .frame_err(frame_err)
    );

    always #5 pix_clk = ~pix_clk;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endfunction

    always @(posedge pix_clk) begin
        cyc <= cyc + 1;
        chk_d <= chk_en;
    end

    always @(negedge pix_clk) begin
        if (frame_err) err_seen++;
        if (chk_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_underflow: got 0x%08h with nothing expected", fft_data);
            end else check("rd_data", fft_data, exp_q.pop_front());
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int hcalc(input int re, input int im);
        int a, b, m;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        m = (((a > b) ? a : b) + ((a > b) ? b : a) / 2) / 64;
        return (m > 719) ? 719 : m;
    endfunction

    task automatic apply(input int n, input bit ok);
        for (int i = 0; i < n; i++) begin
            int hh, p;
            hh = hcalc(fr[i], fi[i]);
            p = peak_m[i] - 2;
            if (p < 0) p = 0;
            if (hh > p) p = hh;
            peak_m[i] = p;
            if (ok) pend_m[i] = 32'((p << 16) | hh);
        end
        if (ok) frame_ready = 1;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) begin
            fr[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12000) - 6000);
            fi[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12000) - 6000);
        end
    endtask

    task automatic beat(input logic signed [15:0] re, input logic signed [15:0] im, input bit last);
        int t = 0;
        if ($urandom_range(0, 3) == 0) @(negedge pix_clk);
        fft_tvalid = 1;
        fft_re = re;
        fft_im = im;
        fft_tlast = last;
        while (!fft_tready && t < 64) begin
            @(negedge pix_clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: tready stayed 0 for %0d cycles, required 1", t);
        end
        @(negedge pix_clk);
        fft_tvalid = 0;
        fft_tlast = 0;
    endtask

    task automatic send(input int n, input int last_at);
        for (int i = 0; i < n; i++) beat(fr[i], fi[i], i == last_at);
    endtask

    task automatic send_good();
        int acc = 0;
        send(N, N - 1);
        apply(N, 1);
        repeat (6) @(negedge pix_clk);
        check("done_tready", fft_tready, 0);
        fft_tvalid = 1;
        for (int i = 0; i < 8; i++) begin
            if (fft_tready) acc++;
            @(negedge pix_clk);
        end
        fft_tvalid = 0;
        check("backpressure_cycles", acc, 0);
        check("frame_err_count", err_seen, err_exp);
    endtask

    task automatic rd(input int addr, input bit use_e, input logic [31:0] e);
        logic [31:0] x;
        x = use_e ? e : ((addr < N && disp_v) ? disp_m[addr] : 32'h0);
        data_req = 1;
        RAM_address = 10'(addr);
        exp_q.push_back(x);
        last_exp = x;
        chk_en = 1;
        @(negedge pix_clk);
    endtask

    task automatic rd_hold();
        data_req = 0;
        RAM_address = 10'($urandom);
        exp_q.push_back(last_exp);
        chk_en = 1;
        @(negedge pix_clk);
    endtask

    task automatic rd_end();
        data_req = 0;
        chk_en = 0;
        @(negedge pix_clk);
    endtask

    task automatic rd_rand(input int n);
        for (int i = 0; i < n; i++) begin
            rd($urandom_range(0, 399), 0, 0);
            if ($urandom_range(0, 2) == 0) rd_hold();
        end
        rd_end();
    endtask

    task automatic vsync();
        bit was;
        was = frame_ready;
        vs_in = 1;
        @(negedge pix_clk);
        check("tready_at_edge", fft_tready, !was);
        @(negedge pix_clk);
        check("tready_after_swap", fft_tready, 1);
        if (was) begin
            disp_m = pend_m;
            disp_v = 1;
            frame_ready = 0;
        end
        vs_in = 0;
        repeat (3) @(negedge pix_clk);
    endtask

    task automatic do_reset();
        int t0, n;
        rstn = 0;
        fft_tvalid = 0;
        fft_tlast = 0;
        data_req = 0;
        vs_in = 0;
        repeat (3) @(negedge pix_clk);
        check("rst_tready", fft_tready, 0);
        check("rst_data", fft_data, 0);
        check("rst_frame_err", frame_err, 0);
        foreach (peak_m[i]) peak_m[i] = 0;
        disp_v = 0;
        frame_ready = 0;
        last_exp = 0;
        rstn = 1;
        t0 = cyc;
        @(negedge pix_clk);
        check("clear_tready", fft_tready, 0);
        rd(5, 1, 32'h0);
        rd_end();
        n = 0;
        while (!fft_tready && n < 2000) begin
            @(negedge pix_clk);
            n++;
        end
        check("clear_len_ok", (cyc - t0 >= N - 2) && (cyc - t0 <= N + 4), 1);
    endtask

    initial begin
        @(negedge pix_clk);
        do_reset();

        rand_frame();
        fr[0] = 6400;   fi[0] = 0;
        fr[3] = 6400;   fi[3] = -3200;
        fr[7] = -32768; fi[7] = -32768;
        send_good();
        rd(3, 1, 32'h0);
        rd_end();
        vsync();
        rd(3, 1, 32'h007D_007D);
        rd(7, 1, 32'h02CF_02CF);
        rd(300, 1, 32'h0);
        rd_hold();
        rd(0, 1, 32'h0064_0064);
        rd_rand(10);

        for (int f = 0; f < 3; f++) begin
            rand_frame();
            fr[0] = 0;
            fi[0] = 0;
            send_good();
            rd(0, 1, 32'h0064_0064 * (f == 0) + 32'((100 - 2 * f) << 16) * (f != 0));
            rd_end();
            vsync();
            rd(0, 1, 32'((98 - 2 * f) << 16));
            rd_rand(6);
        end

        rand_frame();
        send(101, 100);
        apply(101, 0);
        err_exp++;
        repeat (4) @(negedge pix_clk);
        check("short_tready", fft_tready, 1);
        check("short_frame_err", err_seen, err_exp);
        vsync();
        rd(0, 1, 32'h005E_0000);
        rd_rand(6);

        rand_frame();
        send(N, -1);
        apply(N, 0);
        err_exp++;
        repeat (4) @(negedge pix_clk);
        check("notlast_tready", fft_tready, 1);
        check("notlast_frame_err", err_seen, err_exp);

        rand_frame();
        send_good();
        vsync();
        for (int i = 0; i < 12; i++) rd(i, 0, 0);
        rd_rand(8);

        rand_frame();
        send(50, -1);
        do_reset();
        check("midreset_frame_err", err_seen, err_exp);
        rd(0, 1, 32'h0);
        rd_end();
        rand_frame();
        send_good();
        vsync();
        for (int i = 0; i < 12; i++) rd(i, 0, 0);
        rd_rand(8);

        repeat (3) @(negedge pix_clk);
        check("rd_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
